alu_operand_join: RTL

//   Operand-collection and result stage around one ALU instance in a PE tile.

---
 rtl/alu_pe_pkg.sv | 35 +++
 rtl/operand_fifo.sv | 67 ++++++
 rtl/alu_operand_join.sv | 114 +++++++++++
 3 files changed

// File: rtl/alu_pe_pkg.sv
// Shared types and ALU function encodings for the PE tile.
// Each ALU function maps to the set of operands it consumes.
package alu_pe_pkg;

  localparam int DATA_WIDTH   = 32;
  localparam int NUM_OPERANDS = 3;

  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef logic [NUM_OPERANDS-1:0] op_mask_t;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_OR   = 3'd3,
    ALU_PASS = 3'd4,
    ALU_MAC  = 3'd5
  } alu_func_e;

  function automatic op_mask_t func_mask(input alu_func_e f);
    op_mask_t m;
    m = 3'b000;
    unique case (f)
      ALU_ADD:  m = 3'b011;
      ALU_SUB:  m = 3'b011;
      ALU_AND:  m = 3'b011;
      ALU_OR:   m = 3'b011;
      ALU_PASS: m = 3'b001;
      ALU_MAC:  m = 3'b111;
      default:  m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/operand_fifo.sv
// Small synchronous operand FIFO; head is registered storage,
// so a pushed word shows up at the head one cycle later.
module operand_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 2,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int CW = AW + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic [CW-1:0]         count,
  output logic                  full,
  output logic                  empty
);
  import alu_pe_pkg::*;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/alu_operand_join.sv
// Collects the enabled operand streams, fires the ALU once all are
// present, and registers its output into a valid/ready result port.
module alu_operand_join #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            operand_mask,
  input  logic [DATA_WIDTH-1:0] in1_data,
  input  logic                  in1_valid,
  output logic                  in1_ready,
  input  logic [DATA_WIDTH-1:0] in2_data,
  input  logic                  in2_valid,
  output logic                  in2_ready,
  input  logic [DATA_WIDTH-1:0] in3_data,
  input  logic                  in3_valid,
  output logic                  in3_ready,
  output logic [DATA_WIDTH-1:0] alu_in1,
  output logic [DATA_WIDTH-1:0] alu_in2,
  output logic [DATA_WIDTH-1:0] alu_in3,
  input  logic [DATA_WIDTH-1:0] alu_out,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [CNT_WIDTH-1:0]  fire_count
);
  import alu_pe_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_WIDTH-1:0] in_data [NUM_OPERANDS];
  logic [DATA_WIDTH-1:0] head    [NUM_OPERANDS];
  logic [DATA_WIDTH-1:0] opnd    [NUM_OPERANDS];
  logic [CW-1:0]         cnt     [NUM_OPERANDS];
  logic [2:0]            in_valid, in_ready;
  logic [2:0]            push, pop, full, empty;
  logic [2:0]            have;
  logic                  fire;

  logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
  logic                  res_valid_q, res_valid_d;
  logic [CNT_WIDTH-1:0]  fire_count_q, fire_count_d;

  assign in_data[0] = in1_data;
  assign in_data[1] = in2_data;
  assign in_data[2] = in3_data;
  assign in_valid   = {in3_valid, in2_valid, in1_valid};

  for (genvar k = 0; k < NUM_OPERANDS; k++) begin : g_op
    operand_fifo #(
      .DATA_WIDTH(DATA_WIDTH),
      .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push[k]),
      .push_data(in_data[k]),
      .pop      (pop[k]),
      .head     (head[k]),
      .count    (cnt[k]),
      .full     (full[k]),
      .empty    (empty[k])
    );

    // Ready is from registered occupancy only: no bypass when full.
    assign in_ready[k] = operand_mask[k] && !full[k];
    assign push[k]     = in_valid[k] && in_ready[k];
    assign have[k]     = !operand_mask[k] || !empty[k];
    assign pop[k]      = fire && operand_mask[k];
    assign opnd[k]     = (operand_mask[k] && cnt[k] != '0)
                         ? head[k] : '0;
  end

  assign fire = (operand_mask != 3'b000) && (&have)
                && (!res_valid_q || res_ready);

  always_comb begin
    res_data_d   = res_data_q;
    res_valid_d  = res_valid_q;
    fire_count_d = fire_count_q;
    if (fire) begin
      res_data_d   = alu_out;
      res_valid_d  = 1'b1;
      fire_count_d = fire_count_q + CNT_WIDTH'(1);
    end else if (res_valid_q && res_ready) begin
      res_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_data_q   <= '0;
      res_valid_q  <= 1'b0;
      fire_count_q <= '0;
    end else begin
      res_data_q   <= res_data_d;
      res_valid_q  <= res_valid_d;
      fire_count_q <= fire_count_d;
    end
  end

  assign in1_ready  = in_ready[0];
  assign in2_ready  = in_ready[1];
  assign in3_ready  = in_ready[2];
  assign alu_in1    = opnd[0];
  assign alu_in2    = opnd[1];
  assign alu_in3    = opnd[2];
  assign res_data   = res_data_q;
  assign res_valid  = res_valid_q;
  assign fire_count = fire_count_q;

endmodule
